// File: rtl/fft32_pkg.sv
// Shared constants, state encoding, write-back mux codes and the bit-reverse helper
// for the 32-point radix-2 DIT FFT control path.
package fft32_pkg;

   localparam int N_POINTS = 32;
   localparam int LOG2N    = 5;
   localparam int HALF_N   = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_UNLOAD = 3'd4
   } state_t;

   localparam logic [1:0] SEL_IN   = 2'b00;
   localparam logic [1:0] SEL_UP   = 2'b01;
   localparam logic [1:0] SEL_LO   = 2'b10;
   localparam logic [1:0] SEL_IDLE = 2'b11;

   function automatic logic [4:0] bitrev5(input logic [4:0] x);
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

endpackage

// File: rtl/fft32_addr_gen.sv
// Combinational butterfly address generator: maps (stage, butterfly index k)
// to the two operand addresses and the twiddle ROM index.
module fft32_addr_gen
   import fft32_pkg::*;
(
   input  logic [2:0] stage,
   input  logic [3:0] k,
   output logic [4:0] a,
   output logic [4:0] b,
   output logic [3:0] tw_addr
);

   logic [3:0] mask;
   logic [3:0] pos;
   logic [3:0] grp;
   logic [4:0] span;

   always_comb begin
      // span = 2^stage; pos is k's position inside its group, grp the group number
      mask    = ~(4'hF << stage);
      pos     = k & mask;
      grp     = k >> stage;
      span    = 5'd1 << stage;
      a       = ({1'b0, grp} << (stage + 3'd1)) + {1'b0, pos};
      b       = a + span;
      tw_addr = pos << (3'd4 - stage);
   end

endmodule

// File: rtl/fft32_seq_ctrl.sv
// Frame sequencer for the 32-point FFT: bit-reversed load, five butterfly stages
// with a delayed write-back pipeline, then natural-order unload.
module fft32_seq_ctrl
   import fft32_pkg::*;
#(
   parameter int BFLY_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       rd_en,
   output logic [4:0] rd_addr_a,
   output logic [4:0] rd_addr_b,
   output logic       wr_en,
   output logic [4:0] wr_addr,
   output logic [1:0] mux_sel,
   output logic [3:0] tw_addr,
   output logic [2:0] stage,
   output logic       busy,
   output logic       done
);

   localparam int              DW         = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
   localparam int              LAST       = BFLY_LAT - 1;
   localparam logic [DW-1:0]   DRAIN_END  = DW'(BFLY_LAT - 1);
   localparam logic [2:0]      LAST_STAGE = 3'(LOG2N - 1);
   localparam logic [4:0]      LAST_IDX   = 5'(N_POINTS - 1);

   state_t          state, state_nx;
   logic [4:0]      cnt;
   logic [4:0]      idx_nx;
   logic [DW-1:0]   dcnt;
   logic [2:0]      stage_q;
   logic            out_valid_q;
   logic            issue;
   logic            hs;

   logic [4:0]      ag_a, ag_b;
   logic [3:0]      ag_tw;

   logic [BFLY_LAT-1:0] pipe_v;
   logic [4:0]          pipe_a [BFLY_LAT];
   logic [4:0]          pipe_b [BFLY_LAT];
   logic                hold_v;
   logic [4:0]          hold_b;

   fft32_addr_gen u_addr_gen (
      .stage   (stage_q),
      .k       (cnt[4:1]),
      .a       (ag_a),
      .b       (ag_b),
      .tw_addr (ag_tw)
   );

   // Handshakes: a transfer happens in a cycle where valid and ready are both high;
   // a valid source holds its data and address stable until that cycle.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      rd_en     = 1'b0;
      rd_addr_a = 5'd0;
      rd_addr_b = 5'd0;
      tw_addr   = 4'd0;
      wr_en     = 1'b0;
      wr_addr   = 5'd0;
      mux_sel   = SEL_IDLE;
      done      = 1'b0;
      issue     = 1'b0;
      hs        = 1'b0;
      idx_nx    = cnt;

      // Butterfly results return from the pipeline regardless of the current state
      if (pipe_v[LAST]) begin
         wr_en   = 1'b1;
         wr_addr = pipe_a[LAST];
         mux_sel = SEL_UP;
      end else if (hold_v) begin
         wr_en   = 1'b1;
         wr_addr = hold_b;
         mux_sel = SEL_LO;
      end

      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en   = 1'b1;
               wr_addr = bitrev5(cnt);
               mux_sel = SEL_IN;
               if (cnt == LAST_IDX) state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!cnt[0]) begin
               issue     = 1'b1;
               rd_en     = 1'b1;
               rd_addr_a = ag_a;
               rd_addr_b = ag_b;
               tw_addr   = ag_tw;
            end
            if (cnt == LAST_IDX) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (dcnt == DRAIN_END)
               state_nx = (stage_q == LAST_STAGE) ? ST_UNLOAD : ST_ISSUE;
         end
         ST_UNLOAD: begin
            hs = out_valid_q & out_ready;
            if (hs && cnt != LAST_IDX) idx_nx = cnt + 5'd1;
            rd_en     = 1'b1;
            rd_addr_a = idx_nx;
            if (hs && cnt == LAST_IDX) begin
               done     = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= 5'd0;
         dcnt        <= '0;
         stage_q     <= 3'd0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nx;
         out_valid_q <= (state == ST_UNLOAD) && !done;
         case (state)
            ST_LOAD: begin
               stage_q <= 3'd0;
               if (in_valid) cnt <= cnt + 5'd1;
            end
            ST_ISSUE: cnt <= cnt + 5'd1;
            ST_DRAIN: begin
               if (dcnt == DRAIN_END) begin
                  dcnt <= '0;
                  if (stage_q != LAST_STAGE) stage_q <= stage_q + 3'd1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            ST_UNLOAD: begin
               cnt <= done ? 5'd0 : idx_nx;
               if (done) stage_q <= 3'd0;
            end
            default: begin
               cnt  <= 5'd0;
               dcnt <= '0;
            end
         endcase
      end
   end

   // Each issue carries {a, b} for BFLY_LAT cycles; b is written one cycle after a
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         for (int i = 0; i < BFLY_LAT; i++) begin
            pipe_a[i] <= 5'd0;
            pipe_b[i] <= 5'd0;
         end
         hold_v <= 1'b0;
         hold_b <= 5'd0;
      end else begin
         pipe_v[0] <= issue;
         pipe_a[0] <= ag_a;
         pipe_b[0] <= ag_b;
         for (int i = 1; i < BFLY_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
         hold_v <= pipe_v[LAST];
         hold_b <= pipe_b[LAST];
      end
   end

   assign out_valid = out_valid_q;
   assign stage     = stage_q;
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// Directed bench for fft32_seq_ctrl: load order, butterfly issue/write timing,
// unload flow control, mid-frame reset and ignored start pulses.
module tb_fft32_seq_ctrl;

   localparam int W = 23;

   logic       clk, rst_n, start, in_valid, out_ready;
   logic       in_ready, out_valid, rd_en, wr_en, busy, done;
   logic [4:0] rd_addr_a, rd_addr_b, wr_addr;
   logic [1:0] mux_sel;
   logic [3:0] tw_addr;
   logic [2:0] stage;

   int         n_cmp, n_mis, cyc;
   logic [W-1:0] exp_q[$];
   logic [4:0]   out_q[$];
   logic [4:0]   last_rd;
   bit           ab;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fft32_seq_ctrl #(.BFLY_LAT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .mux_sel   (mux_sel),
      .tw_addr   (tw_addr),
      .stage     (stage),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [4:0] brev(input int v);
      logic [4:0] r;
      for (int j = 0; j < 5; j++) r[j] = v[4-j];
      return r;
   endfunction

   task automatic push_wr(input int due, input logic [1:0] sel, input logic [4:0] addr);
      exp_q.push_back({16'(due), sel, addr});
   endtask

   task automatic check_wr();
      logic [W-1:0] e;
      if (exp_q.size() != 0 && exp_q[0][22:7] == 16'(cyc)) begin
         e = exp_q.pop_front();
         chk("wr_en", 32'(wr_en), 32'd1);
         chk("wr_port", 32'({mux_sel, wr_addr}), 32'(e[6:0]));
      end else begin
         chk("wr_idle_en", 32'(wr_en), 32'd0);
         chk("wr_idle_sel", 32'(mux_sel), 32'd3);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic sample();
      @(negedge clk);
      check_wr();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
      chk({tag, "_rd_a"},      32'(rd_addr_a), 32'd0);
      chk({tag, "_rd_b"},      32'(rd_addr_b), 32'd0);
      chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
      chk({tag, "_tw"},        32'(tw_addr),   32'd0);
      chk({tag, "_stage"},     32'(stage),     32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      sample();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      adv();
      start = 1'b0;
   endtask

   task automatic do_load(input bit gaps);
      int i = 0;
      while (i < 32) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            push_wr(cyc, 2'b00, brev(i));
         end
         sample();
         chk("load_in_ready", 32'(in_ready), 32'd1);
         chk("load_busy", 32'(busy), 32'd1);
         if (in_valid) i++;
         adv();
      end
      in_valid = 1'b0;
   endtask

   task automatic do_stages(input bit noise, input int abort_stage, output bit aborted);
      int k, span, a, b, tw;
      aborted = 1'b0;
      for (int s = 0; s < 5; s++) begin
         for (int p = 0; p < 34; p++) begin
            if (s == abort_stage && p == 10) begin
               aborted = 1'b1;
               start = 1'b0;
               return;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            sample();
            chk("iss_in_ready", 32'(in_ready), 32'd0);
            chk("iss_out_valid", 32'(out_valid), 32'd0);
            chk("iss_busy", 32'(busy), 32'd1);
            chk("iss_stage", 32'(stage), 32'(s));
            if (p < 32 && (p % 2) == 0) begin
               k    = p / 2;
               span = 1 << s;
               a    = (k / span) * 2 * span + (k % span);
               b    = a + span;
               tw   = (k % span) * (16 / span);
               chk("iss_rd_en", 32'(rd_en), 32'd1);
               chk("iss_rd_a", 32'(rd_addr_a), 32'(a));
               chk("iss_rd_b", 32'(rd_addr_b), 32'(b));
               chk("iss_tw", 32'(tw_addr), 32'(tw));
               push_wr(cyc + 2, 2'b01, 5'(a));
               push_wr(cyc + 3, 2'b10, 5'(b));
            end else begin
               chk("iss_rd_idle", 32'(rd_en), 32'd0);
            end
            adv();
         end
      end
      start = 1'b0;
   endtask

   task automatic do_unload(input int mode, input bit noise);
      int         idx = 0;
      int         n = 0;
      bit         vm = 1'b0;
      bit         hs;
      bit         fin = 1'b0;
      logic [4:0] ea;
      logic [4:0] eo;
      for (int i = 0; i < 32; i++) out_q.push_back(5'(i));
      while (!fin && n < 400) begin
         if (mode == 0) out_ready = ((n % 4) == 0) || ((n % 4) == 3);
         else           out_ready = 1'($urandom_range(0, 1));
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         sample();
         hs = vm && out_ready;
         ea = (hs && idx < 31) ? 5'(idx + 1) : 5'(idx);
         chk("unl_out_valid", 32'(out_valid), 32'(vm));
         chk("unl_rd_en", 32'(rd_en), 32'd1);
         chk("unl_rd_a", 32'(rd_addr_a), 32'(ea));
         chk("unl_done", 32'(done), 32'(hs && idx == 31));
         chk("unl_busy", 32'(busy), 32'd1);
         chk("unl_in_ready", 32'(in_ready), 32'd0);
         if (hs) begin
            if (out_q.size() == 0) begin
               chk("unl_extra_output", 32'(last_rd), 32'd99);
            end else begin
               eo = out_q.pop_front();
               chk("unl_data_addr", 32'(last_rd), 32'(eo));
            end
            if (idx == 31) fin = 1'b1;
            idx++;
         end
         last_rd = rd_addr_a;
         vm = !fin;
         n++;
         adv();
      end
      out_ready = 1'b0;
      start = 1'b0;
      sample();
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_out_valid", 32'(out_valid), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      chk("post_rd_en", 32'(rd_en), 32'd0);
      chk("post_stage", 32'(stage), 32'd0);
      adv();
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      cyc = 0;
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      last_rd = 5'd0;

      repeat (2) adv();
      sample();
      check_reset_state("rst0");
      adv();
      rst_n = 1'b1;
      sample();
      chk("idle_hold_busy", 32'(busy), 32'd0);
      adv();

      // Frame 1: back-to-back load, 1,0,0,1 unload pattern
      pulse_start();
      do_load(1'b0);
      do_stages(1'b0, 5, ab);
      do_unload(0, 1'b0);

      // Frame 2: load gaps, start noise during ISSUE and UNLOAD, random out_ready
      pulse_start();
      do_load(1'b1);
      do_stages(1'b1, 5, ab);
      do_unload(1, 1'b1);
      sample();
      chk("noise_no_restart", 32'(busy), 32'd0);
      adv();

      // Frame 3: reset during stage 3
      pulse_start();
      do_load(1'b0);
      do_stages(1'b0, 3, ab);
      rst_n = 1'b0;
      exp_q.delete();
      sample();
      check_reset_state("rst_mid");
      adv();
      rst_n = 1'b1;
      sample();
      chk("rst_mid_idle_busy", 32'(busy), 32'd0);
      adv();

      // Frame 4: clean frame after the aborted one
      pulse_start();
      do_load(1'b1);
      do_stages(1'b0, 5, ab);
      do_unload(0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fft32_seq_ctrl.md
Name: fft32_seq_ctrl

Overview:
- Control sequencer for the 32-point radix-2 DIT FFT core.
- Drives the sample-memory addresses and write enable, the twiddle ROM address and the 2-bit select of the 4:1 write-back mux.
- Runs one full frame: load (bit-reversed), 5 butterfly stages, then natural-order unload, with valid/ready handshakes at both ends.
- Contains no datapath; the complex samples never pass through this block.

Parameters:
- N_POINTS, 32, FFT size (fixed at 32 for this core).
- LOG2N, 5, number of stages, equal to log2(N_POINTS).
- BFLY_LAT, 2, butterfly pipeline latency in cycles, from memory read-address issue to the first result at the mux input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts an input sample.
- out_valid  out  1  output sample valid at the memory read port.
- out_ready  in  1  downstream accepts the output sample.
- rd_en  out  1  memory read strobe.
- rd_addr_a  out  5  read address, port A (butterfly upper input, or unload address).
- rd_addr_b  out  5  read address, port B (butterfly lower input).
- wr_en  out  1  memory write strobe.
- wr_addr  out  5  write address.
- mux_sel  out  2  write-back mux select: 00 = external input, 01 = butterfly upper output, 10 = butterfly lower output, 11 = idle/read-back.
- tw_addr  out  4  twiddle ROM index k, selecting W32^k.
- stage  out  3  current stage, 0..4.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the final output handshake.

Behaviour:
- Reset: asynchronous, active-low. Returns to IDLE from any state, including mid-frame; no partial frame resumes.
  - All outputs 0, except mux_sel = 11.
  - All counters and the write pipeline cleared.
- States: IDLE, LOAD, ISSUE, DRAIN, UNLOAD.
- IDLE:
  - in_ready = 0, busy = 0.
  - start = 1 moves to LOAD next cycle.
  - start is ignored in all other states.
- LOAD:
  - in_ready = 1, mux_sel = 00.
  - On each in_valid & in_ready: wr_en = 1 in the same cycle, wr_addr = bitrev5(cnt), cnt increments.
  - The 32nd handshake (cnt = 31) moves to ISSUE with stage = 0.
  - in_ready = 0 outside LOAD.
- ISSUE: 32 cycles per stage, phase counter p = 0..31.
  - On even p, with k = p>>1 (0..15), span = 2^stage, pos = k & (span-1), grp = k >> stage:
    - rd_en = 1.
    - rd_addr_a = grp*2*span + pos.
    - rd_addr_b = rd_addr_a + span.
    - tw_addr = pos << (4 - stage).
  - On odd p, rd_en = 0.
- Write pipeline: each issue pushes {a, b} into a BFLY_LAT-deep delay line.
  - At issue + BFLY_LAT: wr_en = 1, wr_addr = a, mux_sel = 01.
  - At issue + BFLY_LAT + 1: wr_en = 1, wr_addr = b, mux_sel = 10.
  - Issues are two cycles apart, so writes never collide.
- DRAIN:
  - Lasts BFLY_LAT cycles after p = 31, so the last write of the stage lands before the next stage reads (RAW hazard across stages).
  - Then stage increments and returns to ISSUE; after stage 4 moves to UNLOAD.
  - Cost per stage is 32 + BFLY_LAT cycles, i.e. 170 cycles from ISSUE entry to UNLOAD entry with the defaults.
- UNLOAD:
  - Memory has synchronous 1-cycle read; mux_sel = 11, wr_en = 0.
  - rd_en = 1 and rd_addr_a = idx_next, where idx_next = idx + 1 on a handshake, otherwise idx.
  - The first cycle in UNLOAD issues the read of address 0.
  - out_valid rises the following cycle and stays high while idx ≤ 31.
  - Under out_ready = 0, idx and the addresses hold, so the data stays stable.
  - Handshake at idx = 31: done = 1 for that cycle, out_valid = 0 next cycle, return to IDLE.
- mux_sel = 11 and wr_en = 0 whenever no write occurs.
- Widths: all addresses are unsigned and wrap-free by construction; tw_addr ≤ 15.

Decomposition:
- Shared package fft32_pkg holds:
  - constants N_POINTS = 32, LOG2N = 5, HALF_N = 16;
  - the state enum;
  - mux_sel codes SEL_IN, SEL_UP, SEL_LO, SEL_IDLE;
  - the bitrev5 function.
- One sub-module: fft32_addr_gen. It is combinational and maps (stage, k) to (a, b, tw_addr).
- The FSM, counters and write delay line stay in fft32_seq_ctrl.

Test Plan:
- Reset then start, with 32 back-to-back in_valid -> wr_addr sequence 0,16,8,24,4,…,31 with mux_sel = 00; in_ready drops after the 32nd sample.
- Stage 0, then stage 2 -> stage 0 issues (0,1,tw0),(2,3,tw0),…; stage 2 issue k=5 gives a=9, b=13, tw=4; writes appear exactly 2 and 3 cycles after each issue with sel 01/10.
- Stage boundary -> the last write of stage s precedes the first rd_en of stage s+1; ISSUE entry to UNLOAD entry = 170 cycles.
- Unload with out_ready toggling 1,0,0,1… -> addresses 0..31 each delivered exactly once; data and address stable while stalled; done pulses once on idx 31; busy falls the next cycle.
- rst_n asserted during stage 3 -> all outputs reset immediately (mux_sel = 11); a new start performs a full clean frame.
- start pulsed during ISSUE and UNLOAD -> ignored; the frame count and cycle timing are unchanged.
